// File: rtl/consmax_lut_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : consmax_lut_loader_pkg
// Purpose  : LUT geometry defaults and loader state encoding shared with consmax
// Revision : 1.0
// ============================================================================
package consmax_lut_loader_pkg;

    localparam int LUT_ADDR_DEF = 4;
    localparam int LUT_DATA_DEF = 16;

    // Both LUT banks are filled by one load, hence the extra address bit.
    function automatic int num_ent(input int lut_addr);
        return 2 ** (lut_addr + 1);
    endfunction

    localparam int NUM_ENT_DEF = num_ent(LUT_ADDR_DEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/consmax_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : consmax_lut_loader
// Purpose  : Streams a 2*DEPTH FP table into the consmax INT-to-FP LUT write
//            port, LUT0 first then LUT1. Optional checksum: CONSMAX_LUT_CHKSUM_EN
// Revision : 1.0
// ============================================================================
module consmax_lut_loader
    import consmax_lut_loader_pkg::*;
#(
    parameter int LUT_ADDR = LUT_ADDR_DEF,
    parameter int LUT_DATA = LUT_DATA_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                dp_idle,
    input  logic [LUT_DATA-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LUT_ADDR:0]   lut_waddr,
    output logic                lut_wen,
    output logic [LUT_DATA-1:0] lut_wdata,
    output logic                busy,
    output logic                done
`ifdef CONSMAX_LUT_CHKSUM_EN
    ,
    input  logic [LUT_DATA-1:0] exp_chksum,
    output logic                chk_err
`endif
);

    localparam int              NUM_ENT = num_ent(LUT_ADDR);
    localparam logic [LUT_ADDR:0] c_LAST = (LUT_ADDR + 1)'(NUM_ENT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [LUT_ADDR:0]     r_count;
    logic [LUT_ADDR:0]     r_waddr;
    logic                  r_wen;
    logic [LUT_DATA-1:0]   r_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_beat;
    logic                  w_start_acc;
    logic                  w_last;

    assign w_last = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_busy also covers the done-pulse cycle, so a start there is ignored.
    always_comb begin
        w_next_state = r_state;
        w_beat       = 1'b0;
        w_start_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort && !r_busy) begin
                    w_start_acc  = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (dp_idle) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_beat = in_valid;
                    if (in_valid && w_last) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_waddr <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wen  <= w_beat;
            r_done <= (r_state == S_DONE) && !abort;
            r_busy <= (w_next_state != S_IDLE) || ((r_state == S_DONE) && !abort);
            if (w_beat) begin
                r_waddr <= r_count;
                r_wdata <= in_data;
            end
            if (w_next_state == S_IDLE) begin
                r_count <= '0;
            end else if (w_beat && !w_last) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign lut_waddr = r_waddr;
    assign lut_wen   = r_wen;
    assign lut_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef CONSMAX_LUT_CHKSUM_EN
    logic [LUT_DATA-1:0] r_sum;
    logic [LUT_DATA-1:0] r_exp;
    logic                r_chk_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_exp     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_sum     <= '0;
                r_exp     <= exp_chksum;
                r_chk_err <= 1'b0;
            end else if (abort) begin
                r_sum <= '0;
            end else if (w_beat) begin
                r_sum <= r_sum + in_data;
            end
            if ((r_state == S_DONE) && !abort) begin
                r_chk_err <= (r_sum != r_exp);
            end
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_consmax_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_consmax_lut_loader
// Purpose  : Self-checking bench for consmax_lut_loader using a cycle timeline model
// Revision : 1.0
// ============================================================================
module tb_consmax_lut_loader;

    localparam int N = 32;
    localparam int T = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        dp_idle;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  lut_waddr;
    logic        lut_wen;
    logic [15:0] lut_wdata;
    logic        busy;
    logic        done;
`ifdef CONSMAX_LUT_CHKSUM_EN
    logic [15:0] exp_chksum;
    logic        chk_err;
`endif

    int tests = 0;
    int fails = 0;

    // Stimulus and expected output per cycle, cycle 0 = start cycle.
    logic        s_start [T];
    logic        s_abort [T];
    logic        s_dp    [T];
    logic        s_valid [T];
    logic [15:0] s_data  [T];
    logic        e_ready [T];
    logic        e_wen   [T];
    logic        e_done  [T];
    logic        e_busy  [T];
    logic [4:0]  e_addr  [T];
    logic [15:0] e_wdata [T];
    int          m_done_cycle;
    logic [15:0] m_sum;

    consmax_lut_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .dp_idle   (dp_idle),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lut_waddr (lut_waddr),
        .lut_wen   (lut_wen),
        .lut_wdata (lut_wdata),
        .busy      (busy),
        .done      (done)
`ifdef CONSMAX_LUT_CHKSUM_EN
        ,
        .exp_chksum(exp_chksum),
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    // Build the expected timeline from the load rules: busy from cycle 1,
    // dwait cycles of WAIT, LOAD accepts beats, writes one cycle later,
    // done two cycles after the last beat, abort drops the beat and idles.
    task automatic plan(input int dwait, input int vmode, input int abort_beats,
                        input int restart_at, input bit seq_data);
        logic [15:0] dat [N];
        int lstart;
        int k;
        int end_b;
        int abort_cycle;
        bit ended;
        m_sum = '0;
        for (int i = 0; i < N; i++) begin
            dat[i] = seq_data ? 16'(16'h3F80 + i) : 16'($urandom);
            m_sum  = m_sum + dat[i];
        end
        for (int t = 0; t < T; t++) begin
            s_start[t] = (t == 0) || (restart_at > 0 && t == restart_at);
            s_abort[t] = 1'b0;
            s_dp[t]    = (t == 0) || (t > dwait);
            case (vmode)
                0:       s_valid[t] = 1'b1;
                1:       s_valid[t] = (t % 2) == 0;
                default: s_valid[t] = ($urandom_range(0, 3) != 0);
            endcase
            s_data[t]  = 16'($urandom);
            e_ready[t] = 1'b0;
            e_wen[t]   = 1'b0;
            e_done[t]  = 1'b0;
            e_busy[t]  = 1'b0;
            e_addr[t]  = '0;
            e_wdata[t] = '0;
        end
        lstart       = dwait + 2;
        k            = 0;
        ended        = 1'b0;
        abort_cycle  = -1;
        m_done_cycle = -1;
        for (int t = lstart; t < T - 3 && !ended; t++) begin
            e_ready[t] = 1'b1;
            s_data[t]  = dat[k];
            if (abort_beats >= 0 && k == abort_beats) begin
                s_abort[t]  = 1'b1;
                s_valid[t]  = 1'b1;
                abort_cycle = t;
                ended       = 1'b1;
            end else if (s_valid[t]) begin
                e_wen[t+1]   = 1'b1;
                e_addr[t+1]  = 5'(k);
                e_wdata[t+1] = dat[k];
                k++;
                if (k == N) begin
                    m_done_cycle = t + 2;
                    ended        = 1'b1;
                end
            end
        end
        end_b = (abort_cycle >= 0) ? abort_cycle : m_done_cycle;
        for (int t = 1; t <= end_b; t++) e_busy[t] = 1'b1;
        if (m_done_cycle >= 0) e_done[m_done_cycle] = 1'b1;
    endtask

    task automatic run_plan(input logic [15:0] exp_ck, input logic exp_err, output int obs_done);
        obs_done = -1;
        for (int t = 0; t < T; t++) begin
            @(negedge clk);
            tests++;
            if ({in_ready, lut_wen, done, busy} !== {e_ready[t], e_wen[t], e_done[t], e_busy[t]}) begin
                fails++;
                $display("FAIL ctrl cycle %0d: rdy/wen/done/busy got %b required %b", t,
                         {in_ready, lut_wen, done, busy}, {e_ready[t], e_wen[t], e_done[t], e_busy[t]});
            end
            if (e_wen[t]) begin
                tests++;
                if ({lut_waddr, lut_wdata} !== {e_addr[t], e_wdata[t]}) begin
                    fails++;
                    $display("FAIL write cycle %0d: addr/data got %0d/%h required %0d/%h", t,
                             lut_waddr, lut_wdata, e_addr[t], e_wdata[t]);
                end
            end
            if (done === 1'b1 && obs_done < 0) obs_done = t;
`ifdef CONSMAX_LUT_CHKSUM_EN
            if (t == m_done_cycle) begin
                tests++;
                if (chk_err !== exp_err) begin
                    fails++;
                    $display("FAIL chk_err cycle %0d: got %b required %b", t, chk_err, exp_err);
                end
            end
            exp_chksum = exp_ck;
`endif
            start    = s_start[t];
            abort    = s_abort[t];
            dp_idle  = s_dp[t];
            in_valid = s_valid[t];
            in_data  = s_data[t];
        end
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        if (exp_err === 1'bx) obs_done = obs_done;
        if (exp_ck === 16'hxxxx) obs_done = obs_done;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        abort    = 1'b0;
        dp_idle  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
`ifdef CONSMAX_LUT_CHKSUM_EN
        exp_chksum = '0;
`endif
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, lut_wen, busy, done, lut_waddr, lut_wdata} !== '0) begin
            fails++;
            $display("FAIL reset: rdy/wen/busy/done/addr/data got %b required 0",
                     {in_ready, lut_wen, busy, done, lut_waddr, lut_wdata});
        end
`ifdef CONSMAX_LUT_CHKSUM_EN
        tests++;
        if (chk_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_chk_err: got %b required 0", chk_err);
        end
`endif
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        int od;
        plan(0, 0, -1, 0, 1'b1);
        run_plan(m_sum, 1'b0, od);
        tests++;
        if (od !== 35) begin
            fails++;
            $display("FAIL full_load_done_cycle: got %0d required 35", od);
        end
    endtask

    task automatic test_dp_wait();
        int od;
        plan(10, 2, -1, 0, 1'b0);
        run_plan(m_sum, 1'b0, od);
        tests++;
        if (od !== m_done_cycle) begin
            fails++;
            $display("FAIL dp_wait_done_cycle: got %0d required %0d", od, m_done_cycle);
        end
    endtask

    task automatic test_valid_toggle();
        int od;
        plan(0, 1, -1, 14, 1'b0);
        run_plan(m_sum, 1'b0, od);
        tests++;
        if (od !== m_done_cycle) begin
            fails++;
            $display("FAIL toggle_done_cycle: got %0d required %0d", od, m_done_cycle);
        end
    endtask

    task automatic test_abort();
        int od;
        plan(2, 0, 12, 0, 1'b0);
        run_plan(16'h0, 1'b0, od);
        tests++;
        if (od !== -1) begin
            fails++;
            $display("FAIL abort_no_done: done seen at cycle %0d required none", od);
        end
        plan(0, 2, -1, 0, 1'b0);
        run_plan(m_sum, 1'b0, od);
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        dp_idle = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({busy, in_ready, lut_wen, done} !== 4'b0000) begin
                fails++;
                $display("FAIL start_abort cycle %0d: busy/rdy/wen/done got %b required 0000",
                         i, {busy, in_ready, lut_wen, done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_midload();
        start   = 1'b1;
        dp_idle = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (8) begin
            in_data = 16'($urandom);
            @(negedge clk);
        end
        tests++;
        if ({lut_wen, busy, lut_waddr} !== {1'b1, 1'b1, 5'd6}) begin
            fails++;
            $display("FAIL midload_state: wen/busy/addr got %b/%b/%0d required 1/1/6",
                     lut_wen, busy, lut_waddr);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({in_ready, lut_wen, busy, done, lut_waddr, lut_wdata} !== '0) begin
            fails++;
            $display("FAIL rst_midload: outputs got %b required 0",
                     {in_ready, lut_wen, busy, done, lut_waddr, lut_wdata});
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rst_midload_after: rdy/busy got %b required 00", {in_ready, busy});
        end
    endtask

`ifdef CONSMAX_LUT_CHKSUM_EN
    task automatic test_chksum(input logic [15:0] delta);
        int od;
        plan(1, 2, -1, 0, 1'b0);
        run_plan(m_sum + delta, (delta != 16'h0), od);
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_dp_wait();
        test_valid_toggle();
        test_abort();
        test_start_abort();
        test_full_load();
        test_rst_midload();
`ifdef CONSMAX_LUT_CHKSUM_EN
        test_chksum(16'h0);
        test_chksum(16'h1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
